// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter
//   Round-robin arbiter for a shared tristate bus. Exactly one requester is
//   granted the right to drive. Every change of owner is separated by a
//   turnaround gap of TURN_CYC undriven cycles, so two drivers are never
//   enabled in the same cycle.
//
//   Parameters: N (requesters, 2..8), TURN_CYC (gap cycles, >=1),
//               MAX_HOLD (grant cycle limit, >=1, used only with the macro).
//   Ports:
//     clk   in            rising-edge clock
//     rst   in            asynchronous active-high reset
//     req   in  [N]       level request per requester
//     gnt   out [N]       one-hot grant, registered, zero when no owner
//     sel   out [SEL_W]   index of current or last owner (mux select)
//     en    out           tristate output enable, equals |gnt
//     busy  out           high while in GRANT or TURN
//
//   Build option: TRISTATE_ARB_HOLD_LIMIT_EN forces the owner off the bus
//   after MAX_HOLD grant cycles, and it re-arbitrates with lowest priority.
//   When the macro is undefined, a grant is held until req[sel] falls.
//   All outputs come straight from flops.

// Per-requester lane: flags a request at or above the priority pointer.
// These requests win over wrapped-around (below-pointer) requests.
module tristate_bus_arbiter_lane #(
  parameter int SEL_W = 2,
  parameter int IDX   = 0
) (
  input  logic             req_bit,
  input  logic [SEL_W-1:0] ptr,
  output logic             hi
);
  assign hi = req_bit && (SEL_W'(IDX) >= ptr);
endmodule

module tristate_bus_arbiter #(
  parameter int N        = 4,
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 8,
  localparam int SEL_W   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  output logic [N-1:0]     gnt,
  output logic [SEL_W-1:0] sel,
  output logic             en,
  output logic             busy
);
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int TURN_W = $clog2(TURN_CYC + 1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t              state_q, state_d;
  logic [SEL_W-1:0]    ptr_q,  ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [TURN_W-1:0]   turn_q, turn_d;
  logic [N-1:0]        gnt_d;
  logic [SEL_W-1:0]    sel_d;
  logic                en_d, busy_d;

  // ---------------- round-robin pick ----------------
  logic [N-1:0]     req_hi;
  logic             win_vld;
  logic [SEL_W-1:0] win, win_nxt;

  for (genvar i = 0; i < N; i++) begin : g_lane
    tristate_bus_arbiter_lane #(.SEL_W(SEL_W), .IDX(i)) u_lane (
      .req_bit (req[i]),
      .ptr     (ptr_q),
      .hi      (req_hi[i])
    );
  end

  // Lowest set bit at/above ptr wins; if none, the lowest set bit overall
  // (the wrapped part of the scan). Descending loops leave the lowest index.
  always_comb begin
    win_vld = |req;
    win     = '0;
    for (int i = N - 1; i >= 0; i--)
      if (req[i]) win = SEL_W'(i);
    for (int i = N - 1; i >= 0; i--)
      if (req_hi[i]) win = SEL_W'(i);
  end

  assign win_nxt = (win == SEL_W'(N - 1)) ? '0 : win + 1'b1;

  // ---------------- state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- next state ----------------
  logic turn_done, hold_hit;
  assign turn_done = (turn_q == TURN_W'(TURN_CYC));
`ifdef TRISTATE_ARB_HOLD_LIMIT_EN
  assign hold_hit = (hold_q == HOLD_W'(MAX_HOLD));
`else
  assign hold_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_vld) state_d = GRANT;
      GRANT:   if (!req[sel] || hold_hit) state_d = TURN;
      TURN:    if (turn_done) state_d = win_vld ? GRANT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- outputs / datapath next values ----------------
  always_comb begin
    gnt_d  = gnt;
    sel_d  = sel;
    en_d   = en;
    ptr_d  = ptr_q;
    hold_d = hold_q;
    turn_d = turn_q;
    busy_d = (state_d != IDLE);
    if (state_d == GRANT && state_q != GRANT) begin
      // fresh grant out of IDLE or the last TURN cycle
      gnt_d  = N'(1) << win;
      sel_d  = win;
      en_d   = 1'b1;
      ptr_d  = win_nxt;
      hold_d = HOLD_W'(1);
    end else if (state_d == GRANT) begin
      if (hold_q != HOLD_W'(MAX_HOLD)) hold_d = hold_q + 1'b1;
    end else if (state_d == TURN) begin
      // sel keeps the last owner through the gap
      gnt_d  = '0;
      en_d   = 1'b0;
      turn_d = (state_q == TURN) ? turn_q + 1'b1 : TURN_W'(1);
    end else begin
      gnt_d  = '0;
      en_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt    <= '0;
      sel    <= '0;
      en     <= 1'b0;
      busy   <= 1'b0;
      ptr_q  <= '0;
      hold_q <= '0;
      turn_q <= '0;
    end else begin
      gnt    <= gnt_d;
      sel    <= sel_d;
      en     <= en_d;
      busy   <= busy_d;
      ptr_q  <= ptr_d;
      hold_q <= hold_d;
      turn_q <= turn_d;
    end
  end

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
module tb_tristate_bus_arbiter;
  localparam int N        = 4;
  localparam int TURN_CYC = 1;
  localparam int MAX_HOLD = 8;
  localparam int SEL_W    = 2;
`ifdef TRISTATE_ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req;
  logic [N-1:0]     gnt;
  logic [SEL_W-1:0] sel;
  logic             en, busy;

  tristate_bus_arbiter #(.N(N), .TURN_CYC(TURN_CYC), .MAX_HOLD(MAX_HOLD)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .gnt  (gnt),
    .sel  (sel),
    .en   (en),
    .busy (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]     gnt;
    logic [SEL_W-1:0] sel;
    logic             en;
    logic             busy;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // owner = -1 when nobody drives; gap = turnaround cycles still to run.
  int m_owner, m_gap, m_ptr, m_hold, m_sel;
  bit m_busy;

  function automatic void model_reset();
    m_owner = -1; m_gap = 0; m_ptr = 0; m_hold = 0; m_sel = 0; m_busy = 1'b0;
  endfunction

  function automatic void arbitrate(input logic [N-1:0] r);
    bit found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx = (m_ptr + k) % N;
      if (!found && r[idx]) begin
        found   = 1'b1;
        m_owner = idx;
        m_sel   = idx;
        m_ptr   = (idx + 1) % N;
        m_hold  = 1;
      end
    end
    m_busy = found;
  endfunction

  function automatic void model_step(input logic [N-1:0] r);
    if (m_owner >= 0) begin
      if (!r[m_owner] || (HOLD_EN && m_hold == MAX_HOLD)) begin
        m_owner = -1;
        m_gap   = TURN_CYC;
      end else if (m_hold < MAX_HOLD) begin
        m_hold++;
      end
    end else if (m_gap > 0) begin
      if (m_gap > 1) m_gap--;
      else begin
        m_gap = 0;
        arbitrate(r);
      end
    end else begin
      arbitrate(r);
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.gnt  = (m_owner >= 0) ? N'(1) << m_owner : '0;
    e.sel  = SEL_W'(m_sel);
    e.en   = (m_owner >= 0);
    e.busy = m_busy;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [N-1:0] r);
    @(negedge clk);
    req = r;
    model_step(r);
    q.push_back(model_out());
  endtask

  task automatic release_rst(input logic [N-1:0] r);
    rst = 1'b0;
    req = r;
    model_step(r);
    q.push_back(model_out());
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic             prev_en  = 1'b0;
    logic [SEL_W-1:0] prev_sel = '0;
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev_en = 1'b0;
      end else if (q.size() > 0) begin
        e = q.pop_front();
        check("gnt",  gnt,  e.gnt);
        check("sel",  sel,  e.sel);
        check("en",   en,   e.en);
        check("busy", busy, e.busy);
        check("gnt_onehot0", $onehot0(gnt), 1);
        if (prev_en && en) check("owner_switch_without_gap", sel, prev_sel);
        prev_en  = en;
        prev_sel = sel;
      end
    end
  end

  // ---------------- stimulus ----------------
  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] drop;

    // reset with every requester asserting
    rst = 1'b1;
    req = '1;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_gnt",  gnt,  0);
    check("rst_sel",  sel,  0);
    check("rst_en",   en,   0);
    check("rst_busy", busy, 0);
    release_rst('1);
    @(posedge clk); #2;
    check("first_gnt", gnt, 4'b0001);
    check("first_sel", sel, 0);
    repeat (3) step('0);

    // single requester for 5 cycles, then release
    repeat (5) step(4'b0100);
    repeat (3) step('0);

    // reset while requester 1 owns the bus
    step(4'b0010);
    step(4'b0010);
    @(negedge clk);
    check("pre_reset_gnt", gnt, 4'b0010);
    rst = 1'b1;
    #1;
    check("async_rst_gnt", gnt, 0);
    check("async_rst_en",  en,  0);
    model_reset();
    q.delete();
    @(negedge clk);
    release_rst('1);
    @(posedge clk); #2;
    check("rr_order_0", gnt, N'(1) << order[0]);

    // round-robin: each owner keeps 2 cycles, drops, re-raises during TURN
    for (int i = 1; i < 5; i++) begin
      step('1);
      drop = ~(N'(1) << m_owner);
      step(drop);
      step('1);
      @(posedge clk); #2;
      check("rr_order", gnt, N'(1) << order[i]);
    end
    repeat (3) step('0);

    // two requesters held: hold limit rotates them, otherwise 0 keeps it
    repeat (40) step(4'b0011);
    repeat (3) step('0);

    // random traffic
    r = '0;
    repeat (2000) begin
      if ($urandom_range(0, 3) == 0) r = N'($urandom);
      step(r);
    end
    repeat (3) step('0);
    @(posedge clk); #2;
    check("queue_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
